// File: rtl/dmem_sram_bridge.sv
// Memory-stage data port bridge: one split address/data SRAM-bus transaction per request,
// stalling the pipeline until the access completes and holding load data afterwards.
module dmem_sram_bridge (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_en,
    input  logic        mem_we,
    input  logic [3:0]  sel,
    input  logic [1:0]  mem_size,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata_last,
    input  logic        mem_stall,
    output logic [31:0] mem_rdata,
    output logic        stallreq_from_mem,
    output logic        data_req,
    output logic        data_wr,
    output logic [1:0]  data_size,
    output logic [3:0]  data_wstrb,
    output logic [31:0] data_addr,
    output logic [31:0] data_wdata,
    input  logic        data_addr_ok,
    input  logic        data_data_ok,
    input  logic [31:0] data_rdata
);

    typedef enum logic [1:0] {StIdle, StAddr, StData, StDone} state_e;

    state_e      state_q, state_d;
    logic        req_we_q;
    logic [3:0]  req_sel_q;
    logic [1:0]  req_size_q;
    logic [31:0] req_addr_q;
    logic [31:0] req_wdata_q;
    logic [31:0] rdata_q;
    logic [31:0] phys_addr;

    // kseg0/kseg1 are unmapped windows onto the low 512 MB.
    always_comb begin
        phys_addr = mem_addr;
        if (mem_addr[31:30] == 2'b10) begin
            phys_addr = {3'b000, mem_addr[28:0]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            req_we_q    <= 1'b0;
            req_sel_q   <= 4'b0000;
            req_size_q  <= 2'b00;
            req_addr_q  <= 32'h0;
            req_wdata_q <= 32'h0;
            rdata_q     <= 32'h0;
        end else begin
            state_q <= state_d;
            if (state_q == StIdle && mem_en) begin
                req_we_q    <= mem_we;
                req_sel_q   <= sel;
                req_size_q  <= mem_size;
                req_addr_q  <= phys_addr;
                req_wdata_q <= mem_wdata_last;
            end
            if (state_q == StData && data_data_ok && !req_we_q) begin
                rdata_q <= data_rdata;
            end
        end
    end

    always_comb begin
        state_d           = state_q;
        stallreq_from_mem = 1'b0;
        data_req          = 1'b0;
        unique case (state_q)
            StIdle: begin
                stallreq_from_mem = mem_en;
                if (mem_en) begin
                    state_d = StAddr;
                end
            end
            StAddr: begin
                stallreq_from_mem = 1'b1;
                data_req          = 1'b1;
                if (data_addr_ok) begin
                    state_d = StData;
                end
            end
            StData: begin
                stallreq_from_mem = 1'b1;
                if (data_data_ok) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                // Wait out foreign stalls here so the access is never replayed.
                if (!mem_stall) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign data_wr    = req_we_q;
    assign data_size  = req_size_q;
    assign data_addr  = req_addr_q;
    assign data_wdata = req_wdata_q;
    assign data_wstrb = req_we_q ? req_sel_q : 4'b0000;
    assign mem_rdata  = rdata_q;

endmodule

// File: tb/tb_dmem_sram_bridge.sv
// Bench for dmem_sram_bridge: directed and random accesses against a cycle-count model of the
// bus handshake; the bench plays both the pipeline and the SRAM-like bus.
module tb_dmem_sram_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_en;
    logic        mem_we;
    logic [3:0]  sel;
    logic [1:0]  mem_size;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata_last;
    logic        mem_stall;
    logic [31:0] mem_rdata;
    logic        stallreq_from_mem;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [3:0]  data_wstrb;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;
    logic        ext_stall;

    int          total = 0;
    int          bad = 0;
    logic [31:0] model_rdata = 32'h0;

    always #5 clk = ~clk;

    // Pipeline view: the memory stage is held by this block or by any other source.
    assign mem_stall = stallreq_from_mem | ext_stall;

    dmem_sram_bridge dut (
        .clk               (clk),
        .rst               (rst),
        .mem_en            (mem_en),
        .mem_we            (mem_we),
        .sel               (sel),
        .mem_size          (mem_size),
        .mem_addr          (mem_addr),
        .mem_wdata_last    (mem_wdata_last),
        .mem_stall         (mem_stall),
        .mem_rdata         (mem_rdata),
        .stallreq_from_mem (stallreq_from_mem),
        .data_req          (data_req),
        .data_wr           (data_wr),
        .data_size         (data_size),
        .data_wstrb        (data_wstrb),
        .data_addr         (data_addr),
        .data_wdata        (data_wdata),
        .data_addr_ok      (data_addr_ok),
        .data_data_ok      (data_data_ok),
        .data_rdata        (data_rdata)
    );

    function automatic logic [31:0] xlate(input logic [31:0] a);
        if (a >= 32'h8000_0000 && a < 32'hA000_0000) return a - 32'h8000_0000;
        if (a >= 32'hA000_0000 && a < 32'hC000_0000) return a - 32'hA000_0000;
        return a;
    endfunction

    // One access: aw/dw extra wait cycles before addr_ok/data_ok, es cycles of foreign stall
    // in the completion cycle. Inputs are scrambled after the request cycle.
    task automatic run_access(input logic we, input logic [3:0] s, input logic [1:0] sz,
                              input logic [31:0] a, input logic [31:0] wd, input int aw,
                              input int dw, input int es, input logic [31:0] rd,
                              input logic [31:0] chg_addr, input string tag);
        int          n_a;
        int          n_d;
        int          t_done;
        int          last;
        logic        exp_stall;
        logic        exp_req;
        logic [31:0] pa;
        logic [31:0] exp_rd;
        logic [31:0] rd_after;
        logic [3:0]  exp_strb;
        n_a      = aw + 1;
        n_d      = dw + 1;
        t_done   = 1 + n_a + n_d;
        last     = t_done + es;
        pa       = xlate(a);
        rd_after = we ? model_rdata : rd;
        exp_strb = we ? s : 4'b0000;
        for (int c = 0; c <= last; c++) begin
            mem_en = 1'b1;
            if (c == 0) begin
                mem_we = we; sel = s; mem_size = sz; mem_addr = a; mem_wdata_last = wd;
            end else begin
                mem_we = ~we; sel = $urandom; mem_size = 2'($urandom);
                mem_addr = chg_addr; mem_wdata_last = $urandom;
            end
            data_addr_ok = (c == n_a);
            data_data_ok = (c == n_a + n_d);
            data_rdata   = (c == n_a + n_d) ? rd : $urandom;
            ext_stall    = (c >= t_done && c < last);
            @(negedge clk);
            exp_stall = (c < t_done);
            exp_req   = (c >= 1 && c <= n_a);
            exp_rd    = (c >= t_done) ? rd_after : model_rdata;
            total++;
            if (stallreq_from_mem !== exp_stall) begin
                bad++;
                $display("FAIL %s stall c=%0d: got %b want %b", tag, c, stallreq_from_mem,
                         exp_stall);
            end
            total++;
            if (data_req !== exp_req) begin
                bad++;
                $display("FAIL %s data_req c=%0d: got %b want %b", tag, c, data_req, exp_req);
            end
            total++;
            if (mem_rdata !== exp_rd) begin
                bad++;
                $display("FAIL %s mem_rdata c=%0d: got %h want %h", tag, c, mem_rdata, exp_rd);
            end
            if (c >= 1) begin
                total++;
                if (data_addr !== pa) begin
                    bad++;
                    $display("FAIL %s data_addr c=%0d: got %h want %h", tag, c, data_addr, pa);
                end
                total++;
                if (data_wr !== we) begin
                    bad++;
                    $display("FAIL %s data_wr c=%0d: got %b want %b", tag, c, data_wr, we);
                end
                total++;
                if (data_wstrb !== exp_strb) begin
                    bad++;
                    $display("FAIL %s data_wstrb c=%0d: got %b want %b", tag, c, data_wstrb,
                             exp_strb);
                end
                total++;
                if (data_size !== sz) begin
                    bad++;
                    $display("FAIL %s data_size c=%0d: got %0d want %0d", tag, c, data_size, sz);
                end
                total++;
                if (data_wdata !== wd) begin
                    bad++;
                    $display("FAIL %s data_wdata c=%0d: got %h want %h", tag, c, data_wdata, wd);
                end
            end
            @(posedge clk);
            #1;
        end
        model_rdata  = rd_after;
        mem_en       = 1'b0;
        data_addr_ok = 1'b0;
        data_data_ok = 1'b0;
        ext_stall    = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; mem_en = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++;
        if ({data_req, data_wr, data_wstrb, data_size} !== 8'h00) begin
            bad++;
            $display("FAIL reset ctrl: got %b%b%b%b want 0", data_req, data_wr, data_wstrb,
                     data_size);
        end
        total++;
        if (data_addr !== 32'h0 || data_wdata !== 32'h0) begin
            bad++;
            $display("FAIL reset addr/wdata: got %h/%h want 0/0", data_addr, data_wdata);
        end
        total++;
        if (mem_rdata !== 32'h0) begin
            bad++;
            $display("FAIL reset mem_rdata: got %h want 0", mem_rdata);
        end
        total++;
        if (stallreq_from_mem !== 1'b0) begin
            bad++;
            $display("FAIL reset stall idle: got %b want 0", stallreq_from_mem);
        end
        mem_en = 1'b1;
        #1;
        total++;
        if (stallreq_from_mem !== 1'b1) begin
            bad++;
            $display("FAIL reset stall follows mem_en: got %b want 1", stallreq_from_mem);
        end
        mem_en = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        data_addr_ok = 1'b1;
        @(posedge clk); #1;
        data_addr_ok = 1'b0;
        @(negedge clk);
        total++;
        if (data_req !== 1'b0 || stallreq_from_mem !== 1'b0) begin
            bad++;
            $display("FAIL stray addr_ok idle: got req=%b stall=%b want 0/0", data_req,
                     stallreq_from_mem);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_load_zero_wait();
        run_access(1'b0, 4'hF, 2'd2, 32'h8000_0010, 32'h0, 0, 0, 0, 32'hDEAD_BEEF,
                   32'h8000_0010, "load_zero_wait");
    endtask

    task automatic test_store_waits();
        run_access(1'b1, 4'b0100, 2'd0, 32'hBFC0_0002, 32'h5A5A_5A5A, 2, 2, 0, 32'h1111_2222,
                   32'h0000_0100, "store_waits");
    endtask

    task automatic test_ext_stall();
        run_access(1'b0, 4'hF, 2'd2, 32'hA000_0040, 32'h0, 0, 0, 4, 32'h0BAD_F00D,
                   32'hA000_0040, "ext_stall");
    endtask

    task automatic test_useg_input_change();
        run_access(1'b0, 4'hF, 2'd2, 32'h0040_1000, 32'h0, 1, 0, 0, 32'hCAFE_0001,
                   32'h1234_0000, "useg_change");
    endtask

    task automatic test_reset_mid();
        mem_en = 1'b1; mem_we = 1'b0; mem_size = 2'd2; sel = 4'hF; mem_addr = 32'h0000_2000;
        @(posedge clk); #1;
        data_addr_ok = 1'b1;
        @(posedge clk); #1;
        data_addr_ok = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; mem_en = 1'b0; data_data_ok = 1'b1; data_rdata = 32'hFFFF_FFFF;
        model_rdata = 32'h0;
        @(negedge clk);
        total++;
        if ({data_req, data_wr, data_wstrb, data_size, stallreq_from_mem} !== 9'h0) begin
            bad++;
            $display("FAIL reset_mid ctrl: got req=%b wr=%b strb=%b size=%0d stall=%b want 0",
                     data_req, data_wr, data_wstrb, data_size, stallreq_from_mem);
        end
        total++;
        if (data_addr !== 32'h0 || data_wdata !== 32'h0 || mem_rdata !== 32'h0) begin
            bad++;
            $display("FAIL reset_mid data: got addr=%h wdata=%h rdata=%h want 0", data_addr,
                     data_wdata, mem_rdata);
        end
        @(posedge clk); #1;
        data_data_ok = 1'b0;
        @(negedge clk);
        total++;
        if (mem_rdata !== 32'h0 || data_req !== 1'b0 || stallreq_from_mem !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid stray data_ok: got rdata=%h req=%b stall=%b want 0",
                     mem_rdata, data_req, stallreq_from_mem);
        end
        mem_en = 1'b1;
        #1;
        total++;
        if (stallreq_from_mem !== 1'b1) begin
            bad++;
            $display("FAIL reset_mid still idle: got stall %b want 1", stallreq_from_mem);
        end
        mem_en = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        run_access(1'b0, 4'hF, 2'd2, 32'h0000_0300, 32'h0, 0, 0, 0, 32'h1234_5678,
                   32'h0000_0300, "b2b_first");
        run_access(1'b0, 4'hF, 2'd2, 32'h8000_0304, 32'h0, 0, 0, 0, 32'h9ABC_DEF0,
                   32'h8000_0304, "b2b_second");
    endtask

    task automatic test_random();
        logic [3:0] s;
        int         gap;
        for (int i = 0; i < 40; i++) begin
            s = 4'($urandom);
            run_access(1'($urandom), s, 2'($urandom_range(0, 2)), $urandom, $urandom,
                       $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2),
                       $urandom, $urandom, "random");
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
                data_addr_ok = 1'($urandom);
                data_data_ok = 1'($urandom);
                @(negedge clk);
                total++;
                if (data_req !== 1'b0 || stallreq_from_mem !== 1'b0) begin
                    bad++;
                    $display("FAIL random gap: got req=%b stall=%b want 0/0", data_req,
                             stallreq_from_mem);
                end
                @(posedge clk); #1;
            end
            data_addr_ok = 1'b0;
            data_data_ok = 1'b0;
        end
    endtask

    initial begin
        rst = 1'b1; mem_en = 1'b0; mem_we = 1'b0; sel = 4'h0; mem_size = 2'd0;
        mem_addr = 32'h0; mem_wdata_last = 32'h0; ext_stall = 1'b0;
        data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = 32'h0;
        test_reset();
        test_load_zero_wait();
        test_store_waits();
        test_ext_stall();
        test_useg_input_change();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
